regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/regfile_wb_arbiter.sv | 102 ++++++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: data word, register index and the writeback
// arbiter state encoding.
package cpu_types_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   typedef enum logic {
      ARB_CLEAR = 1'b0,
      ARB_RUN   = 1'b1
   } arb_state_t;

   localparam regbits_t REG_ZERO = 5'd0;
   localparam regbits_t REG_LAST = 5'd31;

endpackage

// File: rtl/regfile_wb_arbiter.sv
// Two-requester round-robin writeback arbiter in front of the register file
// write port; optionally zero-fills r1..r31 after reset before serving requests.
module regfile_wb_arbiter
   import cpu_types_pkg::*;
#(
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic     CLK,
   input  logic     RST,

   input  logic     req0_valid,
   input  regbits_t req0_sel,
   input  word_t    req0_dat,
   output logic     req0_ready,

   input  logic     req1_valid,
   input  regbits_t req1_sel,
   input  word_t    req1_dat,
   output logic     req1_ready,

   output logic     rf_wen,
   output regbits_t rf_wsel,
   output word_t    rf_wdat,
   output logic     init_done
);

   localparam arb_state_t RESET_STATE = CLEAR_ON_RESET ? ARB_CLEAR : ARB_RUN;

   arb_state_t state_q;
   regbits_t   clr_cnt_q;
   logic       last1_q;      // 1 = requester 1 won the last handshake
   logic       rf_wen_q;
   regbits_t   rf_wsel_q;
   word_t      rf_wdat_q;
   logic       init_done_q;

   logic       grant0;
   logic       grant1;
   logic       run_ok;
   logic       hs0;
   logic       hs1;

   // On a tie the requester that did not win last time gets the port.
   assign grant0 = req0_valid && (!req1_valid || last1_q);
   assign grant1 = req1_valid && (!req0_valid || !last1_q);
   assign run_ok = (state_q == ARB_RUN) && !RST;

   assign req0_ready = run_ok && grant0;
   assign req1_ready = run_ok && grant1;
   assign hs0        = req0_valid && req0_ready;
   assign hs1        = req1_valid && req1_ready;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= RESET_STATE;
         clr_cnt_q   <= 5'd1;
         last1_q     <= 1'b1;
         rf_wen_q    <= 1'b0;
         rf_wsel_q   <= REG_ZERO;
         rf_wdat_q   <= '0;
         init_done_q <= !CLEAR_ON_RESET;
      end else begin
         case (state_q)
            ARB_CLEAR: begin
               rf_wen_q  <= 1'b1;
               rf_wsel_q <= clr_cnt_q;
               rf_wdat_q <= '0;
               clr_cnt_q <= clr_cnt_q + 5'd1;
               if (clr_cnt_q == REG_LAST) begin
                  state_q     <= ARB_RUN;
                  init_done_q <= 1'b1;
               end
            end
            ARB_RUN: begin
               // Writes to r0 complete the handshake but never reach the file.
               if (hs0) begin
                  rf_wen_q  <= (req0_sel != REG_ZERO);
                  rf_wsel_q <= req0_sel;
                  rf_wdat_q <= req0_dat;
                  last1_q   <= 1'b0;
               end else if (hs1) begin
                  rf_wen_q  <= (req1_sel != REG_ZERO);
                  rf_wsel_q <= req1_sel;
                  rf_wdat_q <= req1_dat;
                  last1_q   <= 1'b1;
               end else begin
                  rf_wen_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= RESET_STATE;
            end
         endcase
      end
   end

   assign rf_wen    = rf_wen_q;
   assign rf_wsel   = rf_wsel_q;
   assign rf_wdat   = rf_wdat_q;
   assign init_done = init_done_q;

endmodule
